// File: rtl/srio_cmd_dispatch_pkg.sv
// rtl/srio_cmd_dispatch_pkg.sv - opcodes, response codes and FSM encoding for srio_cmd_dispatch
package srio_cmd_pkg;

   localparam logic [7:0] OP_SELF_CHECK   = 8'h21;
   localparam logic [7:0] OP_STATUS_QUERY = 8'h23;

   localparam logic [7:0] RSP_READY     = 8'h25;
   localparam logic [7:0] RSP_NOT_READY = 8'h2a;
   localparam logic [7:0] RSP_CMD_ERR   = 8'h2f;

   localparam logic [7:0] CH_NONE = 8'hff;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GET_CH,
      ST_FLUSH,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP0,
      ST_RESP1
   } state_e;

endpackage

// File: rtl/srio_cmd_dispatch_timer.sv
// rtl/srio_cmd_dispatch_timer.sv - saturating per-attempt timeout counter with one-cycle expire
module cmd_timeout_timer #(
   parameter int TIMEOUT_W   = 10,
   parameter int TIMEOUT_VAL = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expire_o
);

   localparam logic [TIMEOUT_W-1:0] CNT_TOP  = TIMEOUT_W'(TIMEOUT_VAL);
   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_VAL - 1);

   logic [TIMEOUT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != CNT_TOP)) begin
         count_d = count_q + TIMEOUT_W'(1);
      end
   end

   // Fires in the enabled cycle whose increment lands on TIMEOUT_VAL; saturation keeps it single-shot.
   assign expire_o = enable_i && !clear_i && (count_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/srio_cmd_dispatch.sv
// rtl/srio_cmd_dispatch.sv - CPU command dispatcher driving per-channel self-check with retrying timeout
module srio_cmd_dispatch #(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_W   = 10,
   parameter int TIMEOUT_VAL = 1000,
   parameter int MAX_RETRY   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] cmd_axis_tdata_in,
   input  logic              cmd_axis_tvalid_in,
   input  logic              cmd_axis_tlast_in,
   output logic              cmd_axis_tready_out,
   output logic [NUM_CH-1:0] self_check_out,
   input  logic [NUM_CH-1:0] dsp_ready_in,
   output logic [DATA_W-1:0] cmd2cpu_tdata_out,
   output logic              cmd2cpu_tvalid_out,
   output logic              cmd2cpu_tlast_out,
   input  logic              cmd2cpu_tready_in,
   output logic              busy_out
);

   import srio_cmd_pkg::*;

   localparam logic [DATA_W-1:0] NUM_CH_L    = DATA_W'(NUM_CH);
   localparam logic [2:0]        MAX_RETRY_L = 3'(MAX_RETRY);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] op_q, op_d, ch_q, ch_d, code_q, code_d;
   logic [2:0]        retry_q, retry_d;
   logic              cmd_tready_q, cmd_tready_d;
   logic [NUM_CH-1:0] self_check_q, self_check_d;
   logic [DATA_W-1:0] rsp_tdata_q, rsp_tdata_d;
   logic              rsp_tvalid_q, rsp_tvalid_d, rsp_tlast_q, rsp_tlast_d;
   logic              busy_q, busy_d;
   logic              cmd_accept, rsp_accept, expire, op_known;

   // Channel is matched against every index at full width, so out-of-range bytes never alias.
   function automatic logic ready_of(input logic [NUM_CH-1:0] rdy, input logic [DATA_W-1:0] ch);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch == DATA_W'(i)) r = rdy[i];
      end
      return r;
   endfunction

   cmd_timeout_timer #(
      .TIMEOUT_W  (TIMEOUT_W),
      .TIMEOUT_VAL(TIMEOUT_VAL)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear_i (state_q == ST_ISSUE),
      .enable_i(state_q == ST_WAIT),
      .expire_o(expire)
   );

   assign cmd_accept = cmd_axis_tvalid_in && cmd_tready_q;
   assign rsp_accept = rsp_tvalid_q && cmd2cpu_tready_in;
   assign op_known   = (op_q == DATA_W'(OP_SELF_CHECK)) || (op_q == DATA_W'(OP_STATUS_QUERY));

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ch_d    = ch_q;
      code_d  = code_q;
      retry_d = retry_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_accept) begin
               op_d = cmd_axis_tdata_in;
               if (cmd_axis_tlast_in) begin
                  ch_d    = DATA_W'(CH_NONE);
                  code_d  = DATA_W'(RSP_CMD_ERR);
                  state_d = ST_RESP0;
               end else begin
                  state_d = ST_GET_CH;
               end
            end
         end
         ST_GET_CH: begin
            if (cmd_accept) begin
               ch_d = cmd_axis_tdata_in;
               if (!cmd_axis_tlast_in) begin
                  state_d = ST_FLUSH;
               end else if ((cmd_axis_tdata_in >= NUM_CH_L) || !op_known) begin
                  code_d  = DATA_W'(RSP_CMD_ERR);
                  state_d = ST_RESP0;
               end else if (op_q == DATA_W'(OP_STATUS_QUERY)) begin
                  code_d  = ready_of(dsp_ready_in, cmd_axis_tdata_in) ? DATA_W'(RSP_READY)
                                                                      : DATA_W'(RSP_NOT_READY);
                  state_d = ST_RESP0;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_FLUSH: begin
            if (cmd_accept && cmd_axis_tlast_in) begin
               code_d  = DATA_W'(RSP_CMD_ERR);
               state_d = ST_RESP0;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (ready_of(dsp_ready_in, ch_q)) begin
               code_d  = DATA_W'(RSP_READY);
               state_d = ST_RESP0;
            end else if (expire) begin
               if (retry_q < MAX_RETRY_L) begin
                  retry_d = retry_q + 3'd1;
                  state_d = ST_ISSUE;
               end else begin
                  code_d  = DATA_W'(RSP_NOT_READY);
                  state_d = ST_RESP0;
               end
            end
         end
         ST_RESP0: if (rsp_accept) state_d = ST_RESP1;
         ST_RESP1: begin
            if (rsp_accept) begin
               retry_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      cmd_tready_d = (state_d == ST_IDLE) || (state_d == ST_GET_CH) || (state_d == ST_FLUSH);
      rsp_tvalid_d = (state_d == ST_RESP0) || (state_d == ST_RESP1);
      rsp_tlast_d  = (state_d == ST_RESP1);
      busy_d       = (state_d != ST_IDLE);
      rsp_tdata_d  = '0;
      if (state_d == ST_RESP0) rsp_tdata_d = code_d;
      if (state_d == ST_RESP1) rsp_tdata_d = ch_d;
      self_check_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         self_check_d[i] = (state_d == ST_ISSUE) && (ch_d == DATA_W'(i));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         ch_q         <= '0;
         code_q       <= '0;
         retry_q      <= '0;
         cmd_tready_q <= 1'b0;
         self_check_q <= '0;
         rsp_tdata_q  <= '0;
         rsp_tvalid_q <= 1'b0;
         rsp_tlast_q  <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         ch_q         <= ch_d;
         code_q       <= code_d;
         retry_q      <= retry_d;
         cmd_tready_q <= cmd_tready_d;
         self_check_q <= self_check_d;
         rsp_tdata_q  <= rsp_tdata_d;
         rsp_tvalid_q <= rsp_tvalid_d;
         rsp_tlast_q  <= rsp_tlast_d;
         busy_q       <= busy_d;
      end
   end

   assign cmd_axis_tready_out = cmd_tready_q;
   assign self_check_out      = self_check_q;
   assign cmd2cpu_tdata_out   = rsp_tdata_q;
   assign cmd2cpu_tvalid_out  = rsp_tvalid_q;
   assign cmd2cpu_tlast_out   = rsp_tlast_q;
   assign busy_out            = busy_q;

endmodule
